des_key_schedule_bank: RTL and testbench

//  Multi-channel DES key-schedule engine for the processing element. Accepts a 64-bit key with

---
 rtl/des_key_schedule_bank.sv | 164 ++++++++++++++++
 tb/tb_des_key_schedule_bank.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule_bank.sv
// Multi-channel DES key-schedule engine: PC-1 on load, sixteen C/D rotate + PC-2 rounds
// (one per cycle) into a per-channel round-key bank, then registered random-access reads.
module des_key_schedule_bank #(
  parameter int NUM_CHANNELS = 2,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid_din,
  output logic                    load_ready_dout,
  input  logic [CH_W-1:0]         load_channel_din,
  input  logic [0:63]             key_din,
  input  logic                    rd_en_din,
  input  logic [CH_W-1:0]         rd_channel_din,
  input  logic [0:3]              rd_round_din,
  input  logic                    rd_decrypt_din,
  output logic [0:47]             rd_key_dout,
  output logic                    rd_valid_dout,
  output logic [NUM_CHANNELS-1:0] ch_ready_dout,
  output logic                    parity_error_dout
);

  // Table entries are 1-based FIPS bit numbers; bit 0 of each vector is FIPS bit 1.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CHANNELS);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] p;
    for (int i = 0; i < 56; i++) p[i] = k[PC1_TAB[i] - 1];
    return p;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] p;
    for (int i = 0; i < 48; i++) p[i] = cd[PC2_TAB[i] - 1];
    return p;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] x, input logic two);
    return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
  endfunction

  // Odd parity per byte is legal; any byte with an even number of ones flags an error.
  function automatic logic parity_bad(input logic [0:63] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad |= ~^k[8*b +: 8];
    return bad;
  endfunction

  state_t            state;
  logic [3:0]        round;
  logic [CH_W-1:0]   exp_ch;
  logic [0:27]       c_reg, d_reg;
  logic [0:27]       c_next, d_next;
  logic [0:55]       cd_init;
  logic              shift_two;
  logic              load_accept;
  logic              rd_in_range;
  logic [3:0]        rd_phys;
  logic [0:47]       bank [NUM_CHANNELS][16];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shift_two   = !(round == 4'd0 || round == 4'd1 || round == 4'd8 || round == 4'd15);
    c_next      = rotl(c_reg, shift_two);
    d_next      = rotl(d_reg, shift_two);
    load_accept = load_valid_din && load_ready_dout && ({1'b0, load_channel_din} < NUM_CH_V);
    rd_in_range = ({1'b0, rd_channel_din} < NUM_CH_V);
    rd_phys     = rd_decrypt_din ? (4'd15 - rd_round_din) : rd_round_din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      round             <= '0;
      c_reg             <= '0;
      d_reg             <= '0;
      cd_init           <= '0;
      exp_ch            <= '0;
      ch_ready_dout     <= '0;
      parity_error_dout <= 1'b0;
      load_ready_dout   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_accept) begin
            state                           <= S_EXPAND;
            load_ready_dout                 <= 1'b0;
            exp_ch                          <= load_channel_din;
            {c_reg, d_reg}                  <= pc1(key_din);
            cd_init                         <= pc1(key_din);
            round                           <= '0;
            ch_ready_dout[load_channel_din] <= 1'b0;
            parity_error_dout               <= CHECK_PARITY && parity_bad(key_din);
          end
        end
        S_EXPAND: begin
          c_reg <= c_next;
          d_reg <= d_next;
          round <= round + 4'd1;
          if (round == 4'd15) begin
            state                 <= S_IDLE;
            load_ready_dout       <= 1'b1;
            ch_ready_dout[exp_ch] <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the bank is deliberately not reset; ch_ready_dout gates every use of its contents.
  always_ff @(posedge clk) begin
    if (reset && state == S_EXPAND) bank[exp_ch][round] <= pc2({c_next, d_next});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_dout <= 1'b0;
      rd_key_dout   <= '0;
    end else if (rd_en_din) begin
      if (rd_in_range && ch_ready_dout[rd_channel_din]) begin
        rd_valid_dout <= 1'b1;
        rd_key_dout   <= bank[rd_channel_din][rd_phys];
      end else begin
        rd_valid_dout <= 1'b0;
        rd_key_dout   <= '0;
      end
    end else begin
      rd_valid_dout <= 1'b0;
    end
  end

  // Shifts total 28 over sixteen rounds, so C/D must come back to their PC-1 values.
  a_cd_wraps: assert property (@(posedge clk) disable iff (!reset)
    (state == S_EXPAND && round == 4'd15) |-> ({c_next, d_next} == cd_init));

endmodule

// File: tb/tb_des_key_schedule_bank.sv
// Self-checking bench for des_key_schedule_bank: FIPS vectors, handshake timing,
// concurrent read/expand, reset mid-expansion, out-of-range channels and random keys.
module tb_des_key_schedule_bank;

  localparam int NCH = 3;
  localparam int CHW = 2;

  localparam logic [63:0] FIPS_KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] FIPS_BAD  = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_TWO   = 64'h0E329232EA6D0D73;
  localparam logic [47:0] FIPS_K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16  = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  logic           clk = 1'b0;
  logic           reset;
  logic           load_valid;
  logic           load_ready;
  logic [CHW-1:0] load_channel;
  logic [0:63]    key_in;
  logic           rd_en;
  logic [CHW-1:0] rd_channel;
  logic [0:3]     rd_round;
  logic           rd_decrypt;
  logic [0:47]    rd_key;
  logic           rd_valid;
  logic [NCH-1:0] ch_ready;
  logic           parity_error;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb_key [NCH];
  bit          sb_ok  [NCH];
  bit          exp_parity;

  typedef struct {
    logic [1:0]  ch;
    logic [3:0]  round;
    logic        dec;
    logic [47:0] key;
    logic        valid;
  } vec_t;
  vec_t vecs [7];

  des_key_schedule_bank #(.NUM_CHANNELS(NCH), .CH_W(CHW), .CHECK_PARITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .load_valid_din(load_valid), .load_ready_dout(load_ready),
    .load_channel_din(load_channel), .key_din(key_in),
    .rd_en_din(rd_en), .rd_channel_din(rd_channel), .rd_round_din(rd_round),
    .rd_decrypt_din(rd_decrypt), .rd_key_dout(rd_key), .rd_valid_dout(rd_valid),
    .ch_ready_dout(ch_ready), .parity_error_dout(parity_error)
  );

  always #5 clk = ~clk;

  // Direct per-round model: PC-1, rotate by the cumulative shift for that round, PC-2.
  function automatic logic [47:0] model_rk(input logic [63:0] key, input int r);
    logic [55:0] p;
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] o;
    for (int i = 0; i < 56; i++) p[55-i] = key[64-PC1_T[i]];
    c  = p[55:28];
    d  = p[27:0];
    c  = (c << CUM[r]) | (c >> (28 - CUM[r]));
    d  = (d << CUM[r]) | (d >> (28 - CUM[r]));
    cd = {c, d};
    for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_T[j]];
    return o;
  endfunction

  function automatic bit model_parity(input logic [63:0] k);
    for (int b = 0; b < 8; b++)
      if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] ch, input logic [3:0] r, input logic dec);
    rd_en      = 1'b1;
    rd_channel = ch;
    rd_round   = r;
    rd_decrypt = dec;
    step();
    rd_en = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] ch, input logic [3:0] r, input logic dec, input string tag);
    int          phys;
    bit          ev;
    logic [47:0] ek;
    phys = dec ? 15 - int'(r) : int'(r);
    ev   = (ch < NCH) && sb_ok[ch];
    ek   = ev ? model_rk(sb_key[ch], phys) : 48'h0;
    do_read(ch, r, dec);
    check({tag, "_valid"}, {63'b0, rd_valid}, {63'b0, ev});
    check({tag, "_key"}, {16'b0, rd_key}, {16'b0, ek});
  endtask

  task automatic sweep(input logic [1:0] ch, input string tag);
    for (int r = 0; r < 16; r++) begin
      read_check(ch, 4'(r), 1'b0, tag);
      read_check(ch, 4'(r), 1'b1, tag);
    end
  endtask

  task automatic load_key(input logic [1:0] ch, input logic [63:0] key);
    int lat;
    int low_cnt;
    load_valid   = 1'b1;
    load_channel = ch;
    key_in       = key;
    step();
    load_valid = 1'b0;
    sb_ok[ch]  = 1'b0;
    lat        = 1;
    low_cnt    = load_ready ? 0 : 1;
    while (!ch_ready[ch] && lat < 40) begin
      step();
      lat++;
      if (!load_ready) low_cnt++;
    end
    check("load_latency", lat, 17);
    check("load_ready_low_cycles", low_cnt, 16);
    check("load_ready_back", {63'b0, load_ready}, 64'd1);
    exp_parity = model_parity(key);
    check("parity_error", {63'b0, parity_error}, {63'b0, exp_parity});
    sb_key[ch] = key;
    sb_ok[ch]  = 1'b1;
  endtask

  initial begin
    int          first, second, accepts, low;
    logic [47:0] held;
    logic [2:0]  ready_before;
    bit          ev;
    logic [47:0] ek;

    vecs[0] = '{ch: 2'd0, round: 4'd0,  dec: 1'b0, key: FIPS_K1,  valid: 1'b1};
    vecs[1] = '{ch: 2'd0, round: 4'd15, dec: 1'b0, key: FIPS_K16, valid: 1'b1};
    vecs[2] = '{ch: 2'd0, round: 4'd0,  dec: 1'b1, key: FIPS_K16, valid: 1'b1};
    vecs[3] = '{ch: 2'd0, round: 4'd15, dec: 1'b1, key: FIPS_K1,  valid: 1'b1};
    vecs[4] = '{ch: 2'd1, round: 4'd5,  dec: 1'b0, key: 48'h0,    valid: 1'b0};
    vecs[5] = '{ch: 2'd3, round: 4'd0,  dec: 1'b0, key: 48'h0,    valid: 1'b0};
    vecs[6] = '{ch: 2'd2, round: 4'd9,  dec: 1'b1, key: 48'h0,    valid: 1'b0};

    for (int c = 0; c < NCH; c++) begin sb_ok[c] = 1'b0; sb_key[c] = '0; end
    exp_parity   = 1'b0;
    reset        = 1'b0;
    load_valid   = 1'b0;
    load_channel = '0;
    key_in       = '0;
    rd_en        = 1'b0;
    rd_channel   = '0;
    rd_round     = '0;
    rd_decrypt   = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    check("rst_load_ready", {63'b0, load_ready}, 64'd1);
    check("rst_ch_ready", {61'b0, ch_ready}, 64'd0);
    check("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
    check("rst_rd_key", {16'b0, rd_key}, 64'd0);
    check("rst_parity", {63'b0, parity_error}, 64'd0);

    // FIPS key into channel 0, then the table of fixed vectors.
    load_key(2'd0, FIPS_KEY);
    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i].ch, vecs[i].round, vecs[i].dec);
      check($sformatf("vec%0d_valid", i), {63'b0, rd_valid}, {63'b0, vecs[i].valid});
      check($sformatf("vec%0d_key", i), {16'b0, rd_key}, {16'b0, vecs[i].key});
    end
    sweep(2'd0, "fips_sweep");

    // rd_en low: valid drops, key holds.
    read_check(2'd0, 4'd3, 1'b0, "pre_hold");
    held = model_rk(FIPS_KEY, 3);
    step();
    check("hold_valid", {63'b0, rd_valid}, 64'd0);
    check("hold_key", {16'b0, rd_key}, {16'b0, held});

    // Load channel 1 while alternating reads of channel 0 and channel 1.
    load_valid   = 1'b1;
    load_channel = 2'd1;
    key_in       = KEY_TWO;
    step();
    load_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 0) begin
        ev = 1'b1;
        ek = model_rk(FIPS_KEY, k % 16);
        do_read(2'd0, 4'(k % 16), 1'b0);
      end else begin
        ev = (k >= 17);
        ek = ev ? model_rk(KEY_TWO, 15 - (k % 16)) : 48'h0;
        do_read(2'd1, 4'(k % 16), 1'b1);
      end
      check($sformatf("mc%0d_valid", k), {63'b0, rd_valid}, {63'b0, ev});
      check($sformatf("mc%0d_key", k), {16'b0, rd_key}, {16'b0, ek});
    end
    sb_key[1]  = KEY_TWO;
    sb_ok[1]   = 1'b1;
    exp_parity = model_parity(KEY_TWO);
    check("mc_parity", {63'b0, parity_error}, {63'b0, exp_parity});
    sweep(2'd1, "ch1_sweep");

    // load_valid held 20 cycles: second accept exactly 17 cycles after the first.
    load_valid   = 1'b1;
    load_channel = 2'd2;
    key_in       = FIPS_BAD;
    first = -1; second = -1; accepts = 0; low = 0;
    for (int i = 0; i < 20; i++) begin
      if (load_ready) begin
        accepts++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end else if (second < 0) begin
        low++;
      end
      step();
    end
    load_valid = 1'b0;
    check("hs_accepts", accepts, 2);
    check("hs_gap", second - first, 17);
    check("hs_low_cycles", low, 16);
    for (int i = 0; i < 40 && !ch_ready[2]; i++) step();
    check("hs_ch2_ready", {63'b0, ch_ready[2]}, 64'd1);
    exp_parity = 1'b1;
    check("hs_parity_bad", {63'b0, parity_error}, 64'd1);
    sb_key[2] = FIPS_BAD;
    sb_ok[2]  = 1'b1;
    read_check(2'd2, 4'd0, 1'b0, "ch2_r0");
    read_check(2'd2, 4'd11, 1'b1, "ch2_r11d");

    // Out-of-range load: no acceptance, no state change.
    ready_before = ch_ready;
    load_valid   = 1'b1;
    load_channel = 2'd3;
    key_in       = KEY_TWO;
    step();
    load_valid = 1'b0;
    check("oor_load_ready", {63'b0, load_ready}, 64'd1);
    check("oor_ch_ready", {61'b0, ch_ready}, {61'b0, ready_before});
    check("oor_parity", {63'b0, parity_error}, {63'b0, exp_parity});
    read_check(2'd3, 4'd7, 1'b1, "oor_read");
    read_check(2'd1, 4'd4, 1'b0, "post_oor_ch1");

    // Reset in round 7 of a channel-1 reload.
    load_valid   = 1'b1;
    load_channel = 2'd1;
    key_in       = FIPS_KEY;
    step();
    load_valid = 1'b0;
    sb_ok[1]   = 1'b0;
    for (int i = 0; i < 7; i++) do_read(2'd0, 4'(i), 1'b0);
    check("pre_rst_ch1_read_ready", {63'b0, ch_ready[1]}, 64'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) sb_ok[c] = 1'b0;
    exp_parity = 1'b0;
    check("mid_rst_ch_ready", {61'b0, ch_ready}, 64'd0);
    check("mid_rst_rd_valid", {63'b0, rd_valid}, 64'd0);
    check("mid_rst_rd_key", {16'b0, rd_key}, 64'd0);
    check("mid_rst_load_ready", {63'b0, load_ready}, 64'd1);
    check("mid_rst_parity", {63'b0, parity_error}, 64'd0);
    read_check(2'd0, 4'd2, 1'b0, "post_rst_ch0");
    load_key(2'd1, KEY_TWO);
    sweep(2'd1, "reload_sweep");

    // Random keys into random channels, all channels spot-checked after each load.
    for (int n = 0; n < 5; n++) begin
      logic [63:0] rk;
      logic [1:0]  rc;
      rk = {$urandom, $urandom};
      rc = 2'($urandom_range(0, NCH - 1));
      load_key(rc, rk);
      sweep(rc, $sformatf("rnd%0d", n));
      for (int c = 0; c < 4; c++)
        read_check(2'(c), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d_ch%0d", n, c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
